// File: rtl/servo_pwm_multich.sv
// servo_pwm_multich: N-channel servo PWM controller behind an Avalon-MM slave.
// All channels share one microsecond frame counter, so their pulses start
// together. Each channel has a clamped target and an optional per-frame slew
// limit on the width actually in use. It also measures the high time of the
// servo's feedback pulse in microseconds.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   address         word address {channel, reg[1:0]}
//                   reg 0 TARGET (RW), 1 CURRENT (RO), 2 RESP (RO), 3 CTRL (RW)
//   read, write     Avalon strobes
//   writedata       write data
//   readdata        read data, registered (valid one cycle after read)
//   pwm_out         registered servo pulses, one per channel
//   pwm_response    asynchronous feedback pulses, one per channel
//   frame_start     one-cycle pulse whenever the frame counter wraps to 0
module servo_pwm_multich #(
    parameter int NUM_CH    = 4,
    parameter int CLK_HZ    = 50000000,
    parameter int PERIOD_US = 20000,
    parameter int W         = 16,
    parameter int MIN_US    = 500,
    parameter int MAX_US    = 2500,
    parameter int RESET_US  = 1500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(NUM_CH*4)-1:0]   address,
    input  logic                          read,
    input  logic                          write,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic [NUM_CH-1:0]             pwm_out,
    input  logic [NUM_CH-1:0]             pwm_response,
    output logic                          frame_start
);
    localparam int AW  = $clog2(NUM_CH*4);
    localparam int DIV = CLK_HZ / 1000000;
    localparam int PW  = $clog2(DIV);
    localparam int FW  = $clog2(PERIOD_US);

    logic [PW-1:0] pre;
    logic          us_tick;
    logic [FW-1:0] fc;

    logic [W-1:0]  target [NUM_CH];
    logic [W-1:0]  cur    [NUM_CH];
    logic [7:0]    step   [NUM_CH];
    logic [W-1:0]  cnt    [NUM_CH];
    logic [W-1:0]  resp   [NUM_CH];
    logic [NUM_CH-1:0] enable, active, resp_valid, counting;
    logic [NUM_CH-1:0] rsync1, rsync2, rprev, rise, fall, cap;
    logic [NUM_CH-1:0] sel, wr_target, wr_ctrl, rd_resp, en_nx, run_nx;

    logic [AW:0]   ch_sel;
    logic [1:0]    reg_sel;
    logic          hit;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    assign unused_bits = ^writedata;

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
        if (v < W'(MIN_US)) return W'(MIN_US);
        if (v > W'(MAX_US)) return W'(MAX_US);
        return v;
    endfunction

    function automatic logic [W-1:0] slew(input logic [W-1:0] t, input logic [W-1:0] c,
                                          input logic [7:0] s);
        logic [W-1:0] d;
        logic [W-1:0] sw;
        sw = W'(s);
        d  = (t >= c) ? t - c : c - t;
        if (s == 8'd0 || d <= sw) return t;
        if (t > c) return c + sw;
        return c - sw;
    endfunction

    // Microsecond prescaler and frame counter
    assign us_tick = (pre == PW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre         <= '0;
            fc          <= '0;
            frame_start <= 1'b0;
        end else begin
            pre         <= us_tick ? '0 : pre + 1'b1;
            frame_start <= us_tick && (fc == FW'(PERIOD_US - 1));
            if (us_tick)
                fc <= (fc == FW'(PERIOD_US - 1)) ? '0 : fc + 1'b1;
        end
    end

    // Bus decode
    always_comb begin
        ch_sel  = {1'b0, address} >> 2;
        reg_sel = address[1:0];
        hit     = {1'b0, address} < (AW+1)'(NUM_CH * 4);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sel[i]       = hit && (ch_sel == (AW+1)'(i));
            wr_target[i] = write && sel[i] && (reg_sel == 2'd0);
            wr_ctrl[i]   = write && sel[i] && (reg_sel == 2'd3);
            rd_resp[i]   = read  && sel[i] && (reg_sel == 2'd2);
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel[i]) begin
                case (reg_sel)
                    2'd0:    rd_mux = 32'(target[i]);
                    2'd1:    rd_mux = 32'(cur[i]);
                    2'd2:    rd_mux = {resp_valid[i], 31'(resp[i])};
                    default: rd_mux = {16'd0, step[i], 7'd0, enable[i]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata <= '0;
        else       readdata <= read ? rd_mux : '0;
    end

    // Per-channel registers and frame-aligned slew update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                target[i] <= W'(RESET_US);
                cur[i]    <= W'(RESET_US);
                step[i]   <= '0;
            end
            enable <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (frame_start)
                    cur[i] <= slew(target[i], cur[i], step[i]);
                if (wr_target[i])
                    target[i] <= clamp(writedata[W-1:0]);
                if (wr_ctrl[i])
                    step[i] <= writedata[15:8];
            end
            enable <= en_nx;
        end
    end

    // A CTRL write bypasses the enable register so a clear drops the output
    // on the very next edge. 'active' only rises at frame_start, which keeps
    // a mid-frame enable from producing a runt pulse.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            en_nx[i]  = wr_ctrl[i] ? writedata[0] : enable[i];
            run_nx[i] = en_nx[i] && (active[i] || frame_start);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active  <= '0;
            pwm_out <= '0;
        end else begin
            active <= run_nx;
            for (int unsigned i = 0; i < NUM_CH; i++)
                pwm_out[i] <= run_nx[i] && (32'(fc) < 32'(cur[i]));
        end
    end

    // Feedback pulse capture. The rise cycle counts its own tick and the fall
    // cycle does not, so the count equals the ticks seen while high.
    assign rise = rsync2 & ~rprev;
    assign fall = ~rsync2 & rprev;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++)
            cap[i] = !rise[i] && counting[i] &&
                     (fall[i] || (us_tick && cnt[i] == {{(W-1){1'b1}}, 1'b0}));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsync1     <= '0;
            rsync2     <= '0;
            rprev      <= '0;
            counting   <= '0;
            resp_valid <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i]  <= '0;
                resp[i] <= '0;
            end
        end else begin
            rsync1 <= pwm_response;
            rsync2 <= rsync1;
            rprev  <= rsync2;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (rise[i]) begin
                    cnt[i]      <= us_tick ? W'(1) : '0;
                    counting[i] <= 1'b1;
                end else if (counting[i]) begin
                    if (fall[i]) begin
                        resp[i]     <= cnt[i];
                        counting[i] <= 1'b0;
                    end else if (us_tick) begin
                        cnt[i] <= cnt[i] + 1'b1;
                        if (cap[i]) begin
                            resp[i]     <= '1;
                            counting[i] <= 1'b0;
                        end
                    end
                end
                if (cap[i])
                    resp_valid[i] <= 1'b1;
                else if (rd_resp[i])
                    resp_valid[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_servo_pwm_multich.sv
// tb_servo_pwm_multich: directed bench for servo_pwm_multich (4 channels,
// 2 MHz clock, 4000 us frame, 12-bit us fields so saturation is reachable).
module tb_servo_pwm_multich;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        read, write;
    logic [31:0] writedata, readdata;
    logic [3:0]  pwm_out, pwm_response;
    logic        frame_start;

    servo_pwm_multich #(
        .NUM_CH(4), .CLK_HZ(2000000), .PERIOD_US(4000), .W(12),
        .MIN_US(500), .MAX_US(2500), .RESET_US(1500)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .pwm_out(pwm_out),
        .pwm_response(pwm_response), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int hi_cnt = 0;
    int oth_cnt = 0;

    always @(negedge clk) begin
        if (pwm_out[0] === 1'b1) hi_cnt++;
        if (pwm_out[3:1] !== 3'b000) oth_cnt++;
    end

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic read_check(input string nm, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(nm, d, exp);
    endtask

    task automatic wait_fs(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 20000);
        check(nm, 32'(frame_start), 32'd1);
    endtask

    initial begin
        vec_t tbl[$];
        logic [31:0] rst_exp [4];
        int hs, os;

        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0;
        writedata = '0; pwm_response = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_rdata", readdata, 32'd0);
        reset = 1'b0;

        rst_exp = '{32'd1500, 32'd1500, 32'd0, 32'd0};
        for (int a = 0; a < 4; a++)
            read_check($sformatf("rst_reg%0d", a), 4'(a), rst_exp[a]);

        // Register map: clamping, read-only registers, CTRL fields, setup
        tbl.push_back('{1'b1, 4'd4,  32'd3000});
        tbl.push_back('{1'b0, 4'd4,  32'd2500});
        tbl.push_back('{1'b1, 4'd4,  32'd100});
        tbl.push_back('{1'b0, 4'd4,  32'd500});
        tbl.push_back('{1'b1, 4'd4,  32'd499});
        tbl.push_back('{1'b0, 4'd4,  32'd500});
        tbl.push_back('{1'b1, 4'd4,  32'd2501});
        tbl.push_back('{1'b0, 4'd4,  32'd2500});
        tbl.push_back('{1'b1, 4'd4,  32'd777});
        tbl.push_back('{1'b0, 4'd4,  32'd777});
        tbl.push_back('{1'b1, 4'd5,  32'h1234});
        tbl.push_back('{1'b0, 4'd5,  32'd1500});
        tbl.push_back('{1'b1, 4'd6,  32'hFFFFFFFF});
        tbl.push_back('{1'b0, 4'd6,  32'd0});
        tbl.push_back('{1'b1, 4'd7,  32'hFFFFFFFF});
        tbl.push_back('{1'b0, 4'd7,  32'h0000FF01});
        tbl.push_back('{1'b1, 4'd7,  32'd0});
        tbl.push_back('{1'b0, 4'd7,  32'd0});
        tbl.push_back('{1'b1, 4'd3,  32'd1});
        tbl.push_back('{1'b1, 4'd0,  32'd1000});
        tbl.push_back('{1'b0, 4'd0,  32'd1000});
        tbl.push_back('{1'b0, 4'd3,  32'd1});
        tbl.push_back('{1'b1, 4'd15, 32'h6400});
        tbl.push_back('{1'b1, 4'd12, 32'd1800});
        tbl.push_back('{1'b0, 4'd15, 32'h6400});
        tbl.push_back('{1'b0, 4'd12, 32'd1800});
        tbl.push_back('{1'b0, 4'd13, 32'd1500});
        foreach (tbl[k]) begin
            if (tbl[k].wr) bus_write(tbl[k].addr, tbl[k].data);
            else read_check($sformatf("vec%0d_a%0d", k, tbl[k].addr), tbl[k].addr, tbl[k].data);
        end

        // Frame 1: slew and pulse width; feedback capture on ch2
        wait_fs("fs1");
        hs = hi_cnt; os = oth_cnt;
        read_check("slew_1600", 4'd13, 32'd1600);
        read_check("ch0_cur", 4'd1, 32'd1000);
        @(negedge clk); pwm_response[2] = 1'b1;
        repeat (2468) @(negedge clk);
        pwm_response[2] = 1'b0;
        repeat (8) @(negedge clk);
        read_check("resp2_valid", 4'd10, 32'h800004D2);
        read_check("resp2_clr", 4'd10, 32'h000004D2);

        wait_fs("fs2");
        check("pulse_width", 32'(hi_cnt - hs), 32'd2000);
        check("others_low", 32'(oth_cnt - os), 32'd0);
        read_check("slew_1700", 4'd13, 32'd1700);

        // Long feedback pulse on ch1 runs across frames
        fork
            begin
                pwm_response[1] = 1'b1;
                repeat (8400) @(negedge clk);
                pwm_response[1] = 1'b0;
            end
        join_none

        wait_fs("fs3");
        read_check("slew_1800", 4'd13, 32'd1800);
        wait_fs("fs4");
        read_check("slew_hold", 4'd13, 32'd1800);
        bus_write(4'd12, 32'd1750);
        read_check("resp1_sat", 4'd6, 32'h80000FFF);
        read_check("resp1_sat_clr", 4'd6, 32'h00000FFF);
        @(negedge clk); pwm_response[1] = 1'b1;
        repeat (20) @(negedge clk);
        pwm_response[1] = 1'b0;
        repeat (8) @(negedge clk);
        read_check("resp1_restart", 4'd6, 32'h8000000A);

        wait_fs("fs5");
        read_check("slew_small", 4'd13, 32'd1750);

        // Enable clear mid-pulse, then mid-frame re-enable
        repeat (598) @(negedge clk);
        check("mid_pulse_high", 32'(pwm_out[0]), 32'd1);
        bus_write(4'd3, 32'd0);
        check("en_clear_low", 32'(pwm_out[0]), 32'd0);
        repeat (100) @(negedge clk);
        bus_write(4'd3, 32'd1);
        repeat (20) @(negedge clk);
        check("no_runt", 32'(pwm_out[0]), 32'd0);
        hs = hi_cnt;
        wait_fs("fs6");
        check("no_runt_frame", 32'(hi_cnt - hs), 32'd0);
        repeat (200) @(negedge clk);
        check("pulse_resume", 32'(pwm_out[0]), 32'd1);

        // Reset in the middle of a pulse
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_pwm", 32'(pwm_out), 32'd0);
        check("arst_fs", 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        read_check("arst_cur0", 4'd1, 32'd1500);
        read_check("arst_tgt0", 4'd0, 32'd1500);
        read_check("arst_ctrl0", 4'd3, 32'd0);
        read_check("arst_resp1", 4'd6, 32'd0);
        read_check("arst_cur3", 4'd13, 32'd1500);
        read_check("arst_ctrl3", 4'd15, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
